ascii_number_parser: RTL and testbench
======================================

// Module: ascii_number_parser
// PURPOSE
//  Streaming ASCII-to-integer parser for the RPN UART front end. It consumes one
//  received character per accepted strobe and accumulates a number in a configurable
//  radix, width and signedness. The number is emitted on a terminator character or a
//  flush edge, via a valid/ready handshake to the RPN stack. Malformed input and
//  overflow are flagged.
// PARAMETERS
//  WIDTH   16  result width in bits (>=4)
//  RADIX   10  10 = digits '0'-'9'; 16 = also 'a'-'f','A'-'F'
//  SIGNED  0   1 = a leading '-' is accepted; out_data is two's complement
// PORTS
//  clk        in   1      system clock, all logic on posedge
//  rst        in   1      synchronous, active-high reset
//  in_data    in   8      ASCII character from the UART receiver
//  in_valid   in   1      in_data is valid this cycle
//  in_ready   out  1      parser accepts in_data; a transfer occurs when in_valid & in_ready
//  flush      in   1      level input; its rising edge acts as a terminator
//  out_data   out  WIDTH  parsed value
//  out_valid  out  1      out_data/out_ovf are valid; held until out_ready
//  out_ready  in   1      consumer accepts the result
//  out_ovf    out  1      result exceeded the representable range (qualified by out_valid)
//  out_err    out  1      one-cycle pulse: malformed token discarded
// BEHAVIOUR
//  Reset: state=IDLE; acc=0; neg=0; ndig=0; last_flush=0.
//   Outputs at reset: out_data=0, out_valid=0, out_ovf=0, out_err=0, in_ready=1.
//  States:
//   IDLE  - no token in progress.
//   ACCUM - a token has started (at least one digit, or a '-').
//   EMIT  - result presented on the output.
//  in_ready = (state != EMIT). While in EMIT, in_valid is ignored and upstream holds.
//  Character classes (on an accepted transfer):
//   digit - valid for RADIX, value d.
//   '-'   - 0x2D.
//   term  - 0x20, 0x0D or 0x0A.
//   other - any other character, including hex letters when RADIX=10.
//  flush_edge = flush & ~last_flush. last_flush is updated every cycle.
//  Digit (IDLE or ACCUM):
//   - acc <= (acc*RADIX + d) mod 2^WIDTH.
//   - ovf sticky-set if the exact value exceeds 2^WIDTH-1.
//   - ndig++ (saturates); state -> ACCUM.
//  '-':
//   - IDLE with SIGNED=1: neg <= 1, state -> ACCUM.
//   - Anywhere else: error.
//  Term or flush_edge:
//   - IDLE: ignored; no empty result is emitted.
//   - ACCUM with ndig=0 (lone '-'): error.
//   - ACCUM with ndig>0: state -> EMIT.
//  Error:
//   - out_err=1 for exactly the next cycle.
//   - acc, neg, ndig and ovf are cleared; state -> IDLE.
//  EMIT entry, registered (the result is updated only on this transition):
//   - out_data <= neg ? (~acc+1) : acc.
//   - out_ovf <= ovf | range error.
//   - Range error (SIGNED=1 only): neg & acc > 2^(WIDTH-1), or ~neg & acc > 2^(WIDTH-1)-1.
//  Latency: a terminator accepted at edge N gives out_valid=1 after edge N+1.
//  EMIT holds out_data, out_ovf and out_valid stable until out_valid & out_ready.
//   On that edge: out_valid <= 0; acc, neg, ndig and ovf are cleared; state -> IDLE.
//   in_ready rises in the following cycle.
//  A flush edge during EMIT is ignored and not queued.
//  A term transfer and a flush_edge in the same cycle produce one emission only.
//  rst has priority over all events, mid-token or mid-EMIT; a pending result is dropped.
// TESTING
//  Default params, bytes "123 " -> one out_valid, out_data=16'd123, out_ovf=0; out_err never set.
//  SIGNED=1, "-42\r" -> out_data=16'hFFD6, out_ovf=0.
//  SIGNED=1:
//   "-32768\n" -> 16'h8000 with ovf=0.
//   "32768\n" -> ovf=1.
//  "70000 " (WIDTH=16, unsigned) -> out_ovf=1, out_data=16'd4464.
//  RADIX=16, "fF " -> 16'h00FF.
//  "1x" -> out_err pulse and no out_valid. Then "5" plus a flush edge -> out_data=5.
//   A flush edge or a lone term in IDLE -> no output.
//  Backpressure: hold out_ready=0 for 3 cycles after "9 ".
//   out_valid and out_data=9 stay stable, and in_ready=0.
//   After out_ready=1 for one cycle -> out_valid=0, and in_ready=1 the next cycle.
//   Assert rst mid-token ("12" then rst, then "3 ") -> out_data=3.

Source files
------------

// File: rtl/ascii_number_parser.sv
// Streaming ASCII-to-integer parser: accumulates digits in a configurable radix/width/sign
// and hands each finished token to the consumer over valid/ready, flagging overflow and bad tokens.
module ascii_number_parser #(
  parameter int WIDTH  = 16,
  parameter int RADIX  = 10,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_ovf,
  output logic             out_err
);

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  localparam int               PW          = WIDTH + 5;
  localparam logic [PW-1:0]    RADIX_W     = PW'(RADIX);
  localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX_POS     = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG_MAG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             neg_q, neg_d;
  logic [3:0]       ndig_q, ndig_d;
  logic             ovf_q, ovf_d;
  logic             last_flush_q, last_flush_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_err_q, out_err_d;

  logic             is_digit, is_minus, is_term;
  logic [3:0]       digit_val;
  logic [PW-1:0]    next_exact;
  logic             digit_ovf, range_err, flush_edge, xfer;

  logic [WIDTH-1:0] acc_n;
  logic             neg_n, ovf_n, tok_n, tok_err, tok_term;
  logic [3:0]       ndig_n;

  always_comb begin
    is_digit  = 1'b0;
    digit_val = 4'd0;
    if (in_data >= 8'h30 && in_data <= 8'h39) begin
      is_digit  = 1'b1;
      digit_val = in_data[3:0];
    end else if (RADIX == 16 &&
                 ((in_data >= 8'h41 && in_data <= 8'h46) ||
                  (in_data >= 8'h61 && in_data <= 8'h66))) begin
      is_digit  = 1'b1;
      digit_val = in_data[3:0] + 4'd9;
    end
    is_minus = (in_data == 8'h2D);
    is_term  = (in_data == 8'h20) || (in_data == 8'h0D) || (in_data == 8'h0A);
  end

  // The extended product keeps the bits above WIDTH so overflow is seen on the digit that causes it.
  assign next_exact = {5'b0, acc_q} * RADIX_W + {{(PW-4){1'b0}}, digit_val};
  assign digit_ovf  = |next_exact[PW-1:WIDTH];
  assign range_err  = SIGNED && (neg_q ? (acc_q > MIN_NEG_MAG) : (acc_q > MAX_POS));
  assign flush_edge = flush & ~last_flush_q;
  assign in_ready   = (state_q != EMIT);
  assign xfer       = in_valid & in_ready;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    neg_d        = neg_q;
    ndig_d       = ndig_q;
    ovf_d        = ovf_q;
    last_flush_d = flush;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_ovf_d    = out_ovf_q;
    out_err_d    = 1'b0;

    acc_n    = acc_q;
    neg_n    = neg_q;
    ndig_n   = ndig_q;
    ovf_n    = ovf_q;
    tok_n    = (state_q == ACCUM);
    tok_err  = 1'b0;
    tok_term = flush_edge;

    case (state_q)
      IDLE, ACCUM: begin
        if (xfer) begin
          if (is_digit) begin
            acc_n  = next_exact[WIDTH-1:0];
            ovf_n  = ovf_q | digit_ovf;
            ndig_n = (ndig_q == 4'hF) ? ndig_q : ndig_q + 4'd1;
            tok_n  = 1'b1;
          end else if (is_minus) begin
            if (state_q == IDLE && SIGNED) begin
              neg_n = 1'b1;
              tok_n = 1'b1;
            end else begin
              tok_err = 1'b1;
            end
          end else if (is_term) begin
            tok_term = 1'b1;
          end else begin
            tok_err = 1'b1;
          end
        end

        // A terminator on a lone '-' is treated as a malformed token.
        if (tok_term && tok_n && ndig_n == 4'd0) begin
          tok_err = 1'b1;
        end

        if (tok_err) begin
          acc_d     = '0;
          neg_d     = 1'b0;
          ndig_d    = 4'd0;
          ovf_d     = 1'b0;
          out_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          acc_d   = acc_n;
          neg_d   = neg_n;
          ndig_d  = ndig_n;
          ovf_d   = ovf_n;
          if (tok_term && tok_n) begin
            state_d = EMIT;
          end else begin
            state_d = tok_n ? ACCUM : IDLE;
          end
        end
      end

      EMIT: begin
        if (!out_valid_q) begin
          out_data_d  = neg_q ? (~acc_q + ONE) : acc_q;
          out_ovf_d   = ovf_q | range_err;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          neg_d       = 1'b0;
          ndig_d      = 4'd0;
          ovf_d       = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      neg_q        <= 1'b0;
      ndig_q       <= 4'd0;
      ovf_q        <= 1'b0;
      last_flush_q <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_ovf_q    <= 1'b0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      neg_q        <= neg_d;
      ndig_q       <= ndig_d;
      ovf_q        <= ovf_d;
      last_flush_q <= last_flush_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_ovf_q    <= out_ovf_d;
      out_err_q    <= out_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_ovf   = out_ovf_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_ascii_number_parser.sv
// Bench for ascii_number_parser: decimal, signed-decimal and hex instances driven by directed
// tokens and random character streams, checked against a token-level model of the parser.
module tb_ascii_number_parser;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  inData[3];
  logic        inValid[3];
  logic        inReady[3];
  logic        flush[3];
  logic [15:0] outData[3];
  logic        outValid[3];
  logic        outReady[3];
  logic        outOvf[3];
  logic        outErr[3];

  ascii_number_parser #(.WIDTH(16), .RADIX(10), .SIGNED(1'b0)) u_dec (
    .clk(clk), .rst(rst), .in_data(inData[0]), .in_valid(inValid[0]), .in_ready(inReady[0]),
    .flush(flush[0]), .out_data(outData[0]), .out_valid(outValid[0]), .out_ready(outReady[0]),
    .out_ovf(outOvf[0]), .out_err(outErr[0]));

  ascii_number_parser #(.WIDTH(16), .RADIX(10), .SIGNED(1'b1)) u_sgn (
    .clk(clk), .rst(rst), .in_data(inData[1]), .in_valid(inValid[1]), .in_ready(inReady[1]),
    .flush(flush[1]), .out_data(outData[1]), .out_valid(outValid[1]), .out_ready(outReady[1]),
    .out_ovf(outOvf[1]), .out_err(outErr[1]));

  ascii_number_parser #(.WIDTH(16), .RADIX(16), .SIGNED(1'b0)) u_hex (
    .clk(clk), .rst(rst), .in_data(inData[2]), .in_valid(inValid[2]), .in_ready(inReady[2]),
    .flush(flush[2]), .out_data(outData[2]), .out_valid(outValid[2]), .out_ready(outReady[2]),
    .out_ovf(outOvf[2]), .out_err(outErr[2]));

  int checks = 0;
  int errors = 0;

  // Token-level model: exact (saturated) magnitude, magnitude mod 2^16, sign, digit count.
  bit          mTok[3];
  bit          mNeg[3];
  int          mNdig[3];
  longint      mSat[3];
  longint      mMod[3];
  logic [16:0] expBuf[3][64];
  int          expHead[3];
  int          expTail[3];
  int          errExp[3];
  int          errSeen[3];
  int          resultsSeen[3];
  int          readyMode[3];
  bit          prevValid[3];
  bit          prevReady[3];
  logic [15:0] prevData[3];
  logic        prevOvf[3];

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int radixOf(input int g);
    return (g == 2) ? 16 : 10;
  endfunction

  function automatic bit signedOf(input int g);
    return (g == 1);
  endfunction

  function automatic int digitOf(input int g, input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (radixOf(g) == 16 && c >= "a" && c <= "f") return int'(c) - 87;
    if (radixOf(g) == 16 && c >= "A" && c <= "F") return int'(c) - 55;
    return -1;
  endfunction

  task automatic modelClear(input int g);
    mTok[g]  = 1'b0;
    mNeg[g]  = 1'b0;
    mNdig[g] = 0;
    mSat[g]  = 0;
    mMod[g]  = 0;
  endtask

  task automatic modelError(input int g);
    errExp[g]++;
    modelClear(g);
  endtask

  task automatic modelEmit(input int g);
    longint data;
    bit     ovf;
    data = mNeg[g] ? ((65536 - mMod[g]) % 65536) : mMod[g];
    ovf  = (mSat[g] > 65535) ||
           (signedOf(g) && (mNeg[g] ? (mSat[g] > 32768) : (mSat[g] > 32767)));
    expBuf[g][expTail[g] % 64] = {ovf, data[15:0]};
    expTail[g]++;
    modelClear(g);
  endtask

  task automatic modelTerm(input int g);
    if (!mTok[g]) return;
    if (mNdig[g] == 0) modelError(g);
    else modelEmit(g);
  endtask

  task automatic modelChar(input int g, input logic [7:0] c);
    int d;
    d = digitOf(g, c);
    if (d >= 0) begin
      mSat[g] = mSat[g] * radixOf(g) + d;
      if (mSat[g] > (longint'(1) << 40)) mSat[g] = longint'(1) << 40;
      mMod[g] = (mMod[g] * radixOf(g) + d) % 65536;
      mNdig[g]++;
      mTok[g] = 1'b1;
    end else if (c == 8'h2D) begin
      if (!mTok[g] && signedOf(g)) begin
        mNeg[g] = 1'b1;
        mTok[g] = 1'b1;
      end else begin
        modelError(g);
      end
    end else if (c == 8'h20 || c == 8'h0D || c == 8'h0A) begin
      modelTerm(g);
    end else begin
      modelError(g);
    end
  endtask

  task automatic modelReset();
    for (int g = 0; g < 3; g++) begin
      modelClear(g);
      expHead[g] = expTail[g];
    end
  endtask

  task automatic waitReady(input int g, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (inReady[g]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("in_ready wait", inReady[g], 1);
  endtask

  task automatic sendChar(input int g, input logic [7:0] c, input bit withFlush);
    bit ok;
    waitReady(g, ok);
    if (!ok) return;
    inValid[g] = 1'b1;
    inData[g]  = c;
    if (withFlush) flush[g] = 1'b1;
    @(posedge clk);
    modelChar(g, c);
    if (withFlush) modelTerm(g);
    #1;
    inValid[g] = 1'b0;
    flush[g]   = 1'b0;
  endtask

  task automatic sendStr(input int g, input string s);
    for (int i = 0; i < s.len(); i++) sendChar(g, s[i], 1'b0);
  endtask

  task automatic pulseFlush(input int g);
    bit ok;
    waitReady(g, ok);
    if (!ok) return;
    flush[g] = 1'b1;
    @(posedge clk);
    modelTerm(g);
    @(negedge clk);
    flush[g] = 1'b0;
  endtask

  task automatic waitResult(input int g, input string name, input longint expData, input bit expOvf);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (outValid[g]) break;
    end
    checkOutput({name, " valid"}, outValid[g], 1);
    checkOutput({name, " data"}, outData[g], expData);
    checkOutput({name, " ovf"}, outOvf[g], expOvf);
  endtask

  task automatic waitIdle(input int g);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (!outValid[g] && inReady[g]) break;
    end
    checkOutput("return to idle", inReady[g], 1);
  endtask

  task automatic expectQuiet(input int g, input int cycles, input string name);
    int r;
    @(negedge clk);
    r = resultsSeen[g];
    repeat (cycles) @(negedge clk);
    checkOutput(name, resultsSeen[g], r);
  endtask

  task automatic applyStimulus(input int g, input int n);
    logic [7:0] c;
    int r;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 99);
      if (r < 50) c = 8'(48 + $urandom_range(0, 9));
      else if (r < 60) c = $urandom_range(0, 1) ? 8'(97 + $urandom_range(0, 5)) : 8'(65 + $urandom_range(0, 5));
      else if (r < 68) c = 8'h2D;
      else if (r < 85) begin
        case ($urandom_range(0, 2))
          0: c = 8'h20;
          1: c = 8'h0D;
          default: c = 8'h0A;
        endcase
      end else if (r < 92) begin
        pulseFlush(g);
        continue;
      end else c = 8'($urandom_range(0, 255));
      sendChar(g, c, 1'b0);
    end
  endtask

  // Per-cycle compare process and consumer-side out_ready driver.
  initial begin
    forever begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        if (rst) begin
          prevValid[g] = 1'b0;
        end else begin
          if (outErr[g]) errSeen[g]++;
          if (prevValid[g] && !prevReady[g]) begin
            checkOutput("hold valid", outValid[g], 1);
            checkOutput("hold data", outData[g], prevData[g]);
            checkOutput("hold ovf", outOvf[g], prevOvf[g]);
          end
          if (prevValid[g] && prevReady[g]) begin
            checkOutput("release valid", outValid[g], 0);
            checkOutput("release in_ready", inReady[g], 1);
          end
          if (outValid[g] && !prevValid[g]) begin
            resultsSeen[g]++;
            checkOutput("in_ready while presenting", inReady[g], 0);
            checkOutput("pending results", expTail[g] - expHead[g], 1);
            if (expTail[g] != expHead[g]) begin
              checkOutput("model data", outData[g], expBuf[g][expHead[g] % 64][15:0]);
              checkOutput("model ovf", outOvf[g], expBuf[g][expHead[g] % 64][16]);
              expHead[g]++;
            end
          end
          prevValid[g] = outValid[g];
          prevData[g]  = outData[g];
          prevOvf[g]   = outOvf[g];
        end
        case (readyMode[g])
          0: outReady[g] = 1'b0;
          1: outReady[g] = 1'b1;
          default: outReady[g] = ($urandom_range(0, 2) != 0);
        endcase
        prevReady[g] = outReady[g];
      end
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int e;
    rst = 1'b1;
    for (int g = 0; g < 3; g++) begin
      inData[g] = 8'h00; inValid[g] = 1'b0; flush[g] = 1'b0; outReady[g] = 1'b1;
      readyMode[g] = 1; expHead[g] = 0; expTail[g] = 0;
      errExp[g] = 0; errSeen[g] = 0; resultsSeen[g] = 0;
    end
    modelReset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      checkOutput("reset out_data", outData[g], 0);
      checkOutput("reset out_valid", outValid[g], 0);
      checkOutput("reset out_ovf", outOvf[g], 0);
      checkOutput("reset out_err", outErr[g], 0);
      checkOutput("reset in_ready", inReady[g], 1);
    end
    rst = 1'b0;

    // Basic token and terminator-to-valid latency.
    readyMode[0] = 0;
    sendStr(0, "123 ");
    @(negedge clk);
    checkOutput("latency edge N", outValid[0], 0);
    @(negedge clk);
    checkOutput("latency edge N+1", outValid[0], 1);
    checkOutput("123 data", outData[0], 123);
    checkOutput("123 ovf", outOvf[0], 0);
    readyMode[0] = 1;
    waitIdle(0);

    // Backpressure, with a flush edge during the held result.
    readyMode[0] = 0;
    sendStr(0, "9 ");
    waitResult(0, "backpressure", 9, 0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("bp valid", outValid[0], 1);
      checkOutput("bp data", outData[0], 9);
      checkOutput("bp in_ready", inReady[0], 0);
    end
    flush[0] = 1'b1;
    @(negedge clk);
    flush[0] = 1'b0;
    readyMode[0] = 1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (!outValid[0]) break;
    end
    checkOutput("bp released valid", outValid[0], 0);
    checkOutput("bp released in_ready", inReady[0], 1);
    expectQuiet(0, 5, "flush during result not queued");

    sendStr(0, "70000 ");
    waitResult(0, "70000", 4464, 1);

    e = errSeen[0];
    sendStr(0, "1x");
    expectQuiet(0, 4, "1x no result");
    checkOutput("1x err pulse", errSeen[0] - e, 1);
    sendStr(0, "5");
    pulseFlush(0);
    waitResult(0, "5 flush", 5, 0);
    waitIdle(0);

    pulseFlush(0);
    sendStr(0, " ");
    expectQuiet(0, 5, "idle flush/term no result");

    e = errSeen[0];
    sendStr(0, "fF ");
    expectQuiet(0, 4, "hex letters in decimal no result");
    checkOutput("hex letters in decimal errs", errSeen[0] - e, 2);

    sendStr(0, "7");
    sendChar(0, 8'h20, 1'b1);
    waitResult(0, "term+flush", 7, 0);
    expectQuiet(0, 6, "term+flush single result");

    // Signed instance.
    sendStr(1, "-42");
    sendChar(1, 8'h0D, 1'b0);
    waitResult(1, "-42", 16'hFFD6, 0);
    sendStr(1, "-32768");
    sendChar(1, 8'h0A, 1'b0);
    waitResult(1, "-32768", 16'h8000, 0);
    sendStr(1, "32768");
    sendChar(1, 8'h0A, 1'b0);
    waitResult(1, "32768", 16'h8000, 1);
    e = errSeen[1];
    sendStr(1, "-");
    sendChar(1, 8'h0A, 1'b0);
    sendStr(1, "4-");
    expectQuiet(1, 4, "signed malformed no result");
    checkOutput("signed malformed errs", errSeen[1] - e, 2);

    // Hex instance.
    sendStr(2, "fF ");
    waitResult(2, "hex fF", 16'h00FF, 0);
    sendStr(2, "123 ");
    waitResult(2, "hex 123", 16'h0123, 0);

    // Reset mid-token drops the partial number.
    sendStr(0, "12");
    @(negedge clk);
    rst = 1'b1;
    modelReset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sendStr(0, "3 ");
    waitResult(0, "reset mid-token", 3, 0);
    waitIdle(0);

    // Random character streams with random consumer backpressure.
    for (int g = 0; g < 3; g++) begin
      readyMode[g] = 2;
      applyStimulus(g, 400);
      for (int n = 0; n < 200; n++) begin
        @(negedge clk);
        if (expHead[g] == expTail[g] && !outValid[g]) break;
      end
      checkOutput("drain pending", expTail[g] - expHead[g], 0);
      readyMode[g] = 1;
    end

    repeat (4) @(negedge clk);
    for (int g = 0; g < 3; g++) checkOutput("error pulse count", errSeen[g], errExp[g]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
